// File: rtl/slib_input_filter_multi_if.sv
// Bus for the multi-channel input filter.
// The master drives the sample tick, the clear and the raw pad inputs.
// The slave (the filter) returns the filtered levels, the edge pulses and the summary flag.
interface slib_input_filter_multi_if #(
  parameter int CHANNELS = 4
);
  logic                CE;
  logic                CLR;
  logic [CHANNELS-1:0] D;
  logic [CHANNELS-1:0] Q;
  logic [CHANNELS-1:0] RISE;
  logic [CHANNELS-1:0] FALL;
  logic                CHANGED;

  modport master (
    output CE,
    output CLR,
    output D,
    input  Q,
    input  RISE,
    input  FALL,
    input  CHANGED
  );

  modport slave (
    input  CE,
    input  CLR,
    input  D,
    output Q,
    output RISE,
    output FALL,
    output CHANGED
  );
endinterface

// File: rtl/slib_input_filter_multi.sv
// Multi-channel debounce / glitch filter for slow asynchronous inputs such as
// UART modem lines and RXD.
// Each channel has these parts:
//   - an optional synchroniser;
//   - a saturating up/down counter, advanced on CE ticks;
//   - a hysteretic output that only moves at the counter extremes;
//   - registered rise/fall pulses.
// CHANGED flags any edge on any channel, in the same cycle as the pulses.
module slib_input_filter_multi #(
  parameter int CHANNELS    = 4,
  parameter int SIZE        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  slib_input_filter_multi_if.slave     bus
);

  localparam int              CW      = (SIZE < 1) ? 1 : $clog2(SIZE + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(SIZE);

  // Saturating step toward the sampled level; the counter never wraps.
  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] cnt,
                                             input logic          up);
    if (up) begin
      return (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end
    return (cnt == '0) ? cnt : cnt - CW'(1);
  endfunction

  // Hysteresis:
  //   - the output is set only at full count and cleared only at zero;
  //   - anything in between keeps the previous level.
  function automatic logic hyst(input logic [CW-1:0] cnt, input logic q);
    if (cnt == CNT_MAX) return 1'b1;
    if (cnt == '0)      return 1'b0;
    return q;
  endfunction

  logic [CHANNELS-1:0] ds_p0;

  // ---- stage p0: input synchronisation (runs every edge, ignores CE/CLR)
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ds_p0 = bus.D;
    end else begin : g_sync
      logic [CHANNELS-1:0] sync_p0 [SYNC_STAGES];

      // Shift the raw inputs through the metastability chain.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= '0;
        end else begin
          sync_p0[0] <= bus.D;
          for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
        end
      end

      assign ds_p0 = sync_p0[SYNC_STAGES-1];
    end
  endgenerate

  logic [CW-1:0]       cnt_p1  [CHANNELS];
  logic [CW-1:0]       cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] q_p1;
  logic [CHANNELS-1:0] q_nxt;
  logic [CHANNELS-1:0] rise_p1;
  logic [CHANNELS-1:0] fall_p1;
  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;
  logic                chg_p1;

  // Next counter and output levels.
  // CLR overrides everything.
  // The counter moves only on CE ticks.
  // Q is evaluated every edge from the counter value before the update.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = cnt_p1[i];
      q_nxt[i]   = 1'b0;
      if (bus.CLR) begin
        cnt_nxt[i] = '0;
        q_nxt[i]   = 1'b0;
      end else begin
        if (bus.CE) cnt_nxt[i] = sat_step(cnt_p1[i], ds_p0[i]);
        q_nxt[i] = hyst(cnt_p1[i], q_p1[i]);
      end
    end
    rise_nxt = ~q_p1 &  q_nxt;
    fall_nxt =  q_p1 & ~q_nxt;
  end

  // ---- stage p1: counters
  // Per-channel filter counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < CHANNELS; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_p1[i] <= cnt_nxt[i];
    end
  end

  // ---- stage p1: filtered level, edge pulses and summary flag
  // Async reset clears the outputs silently, so no FALL pulse comes from reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_p1    <= '0;
      rise_p1 <= '0;
      fall_p1 <= '0;
      chg_p1  <= 1'b0;
    end else begin
      q_p1    <= q_nxt;
      rise_p1 <= rise_nxt;
      fall_p1 <= fall_nxt;
      chg_p1  <= |(rise_nxt | fall_nxt);
    end
  end

  assign bus.Q       = q_p1;
  assign bus.RISE    = rise_p1;
  assign bus.FALL    = fall_p1;
  assign bus.CHANGED = chg_p1;

endmodule

// File: tb/tb_slib_input_filter_multi.sv
// Directed bench for slib_input_filter_multi.
// Instance 0 uses the defaults (4 channels, SIZE=2, two sync stages).
// Instance 1 is a single channel with SIZE=4 and no synchroniser, for the hysteresis band.
// Expected outputs are queued as stimulus is driven and compared after the following edge.
module tb_slib_input_filter_multi;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  slib_input_filter_multi_if #(.CHANNELS(4)) bus0 ();
  slib_input_filter_multi_if #(.CHANNELS(1)) bus1 ();

  slib_input_filter_multi #(.CHANNELS(4), .SIZE(2), .SYNC_STAGES(2)) dut0 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus0)
  );

  slib_input_filter_multi #(.CHANNELS(1), .SIZE(4), .SYNC_STAGES(0)) dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus1)
  );

  typedef struct {
    string      tag;
    int         dut;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push(string tag, int dut, logic [3:0] q, logic [3:0] r,
                               logic [3:0] f, logic c);
    exp_t e;
    e.tag  = tag;
    e.dut  = dut;
    e.q    = q;
    e.rise = r;
    e.fall = f;
    e.chg  = c;
    sb.push_back(e);
  endfunction

  task automatic compare();
    exp_t       e;
    logic [3:0] oq, orise, ofall;
    logic       oc;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed 0 entries expected >=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        oq = bus0.Q; orise = bus0.RISE; ofall = bus0.FALL; oc = bus0.CHANGED;
      end else begin
        oq = {3'b000, bus1.Q}; orise = {3'b000, bus1.RISE};
        ofall = {3'b000, bus1.FALL}; oc = bus1.CHANGED;
      end
      checks++;
      assert (oq === e.q) else begin
        errors++;
        $error("FAIL %s.Q observed %h expected %h", e.tag, oq, e.q);
      end
      checks++;
      assert (orise === e.rise) else begin
        errors++;
        $error("FAIL %s.RISE observed %h expected %h", e.tag, orise, e.rise);
      end
      checks++;
      assert (ofall === e.fall) else begin
        errors++;
        $error("FAIL %s.FALL observed %h expected %h", e.tag, ofall, e.fall);
      end
      checks++;
      assert (oc === e.chg) else begin
        errors++;
        $error("FAIL %s.CHANGED observed %b expected %b", e.tag, oc, e.chg);
      end
    end
  endtask

  // Queue the expectation, clock once, sample 1 time unit after the edge.
  task automatic step(string tag, int dut, logic [3:0] q, logic [3:0] r,
                      logic [3:0] f, logic c);
    push(tag, dut, q, r, f, c);
    @(posedge CLK);
    #1;
    compare();
  endtask

  initial begin
    RST_N     = 1'b0;
    bus0.CE   = 1'b1;
    bus0.CLR  = 1'b0;
    bus0.D    = 4'hF;
    bus1.CE   = 1'b0;
    bus1.CLR  = 1'b0;
    bus1.D    = 1'b0;

    // Reset held across edges with D high: everything stays 0.
    repeat (2) @(posedge CLK);
    #1;
    push("reset0", 0, 4'h0, 4'h0, 4'h0, 1'b0);
    compare();
    push("reset1", 1, 4'h0, 4'h0, 4'h0, 1'b0);
    compare();
    RST_N = 1'b1;

    // Rise latency is SYNC_STAGES + SIZE + 1 = 5 edges.
    for (int k = 1; k <= 4; k++) step("rise_wait", 0, 4'h0, 4'h0, 4'h0, 1'b0);
    step("rise_edge", 0, 4'hF, 4'hF, 4'h0, 1'b1);
    step("rise_after", 0, 4'hF, 4'h0, 4'h0, 1'b0);

    // Falling on ch0/ch2 from saturation is symmetric: 5 edges.
    bus0.D = 4'hA;
    for (int k = 1; k <= 4; k++) step("fall_wait", 0, 4'hF, 4'h0, 4'h0, 1'b0);
    step("fall_edge", 0, 4'hA, 4'h0, 4'h5, 1'b1);
    step("fall_after", 0, 4'hA, 4'h0, 4'h0, 1'b0);

    // CLR with Q=1010 and CE=1: visible FALL on ch1/ch3, then recovery.
    bus0.CLR = 1'b1;
    step("clr_edge", 0, 4'h0, 4'h0, 4'hA, 1'b1);
    bus0.CLR = 1'b0;
    step("clr_hold1", 0, 4'h0, 4'h0, 4'h0, 1'b0);
    step("clr_hold2", 0, 4'h0, 4'h0, 4'h0, 1'b0);
    step("clr_rise", 0, 4'hA, 4'hA, 4'h0, 1'b1);
    step("clr_after", 0, 4'hA, 4'h0, 4'h0, 1'b0);

    // One-tick glitch on ch0 must not reach Q.
    bus0.D = 4'hB;
    step("glitch_on", 0, 4'hA, 4'h0, 4'h0, 1'b0);
    bus0.D = 4'hA;
    for (int k = 1; k <= 4; k++) step("glitch_off", 0, 4'hA, 4'h0, 4'h0, 1'b0);

    // Opposite moves on all channels at once, held 20 ticks (saturation).
    bus0.D = 4'h5;
    for (int k = 1; k <= 20; k++) begin
      if (k < 5)       step("sat_wait", 0, 4'hA, 4'h0, 4'h0, 1'b0);
      else if (k == 5) step("sat_edge", 0, 4'h5, 4'h5, 4'hA, 1'b1);
      else             step("sat_hold", 0, 4'h5, 4'h0, 4'h0, 1'b0);
    end

    // CE every 4th cycle: ch1 rises one edge after its second tick.
    bus0.D = 4'h7;
    for (int k = 0; k < 12; k++) begin
      bus0.CE = ((k % 4) == 3);
      if (k < 8)       step("ce_wait", 0, 4'h5, 4'h0, 4'h0, 1'b0);
      else if (k == 8) step("ce_rise", 0, 4'h7, 4'h2, 4'h0, 1'b1);
      else             step("ce_after", 0, 4'h7, 4'h0, 4'h0, 1'b0);
    end

    // CE low: counters frozen, Q unchanged even though D dropped.
    bus0.CE = 1'b0;
    bus0.D  = 4'h0;
    for (int k = 1; k <= 8; k++) step("ce_off", 0, 4'h7, 4'h0, 4'h0, 1'b0);

    // Reset mid-count: Q drops at once with no FALL pulse.
    bus0.CE = 1'b1;
    step("mid_count", 0, 4'h7, 4'h0, 4'h0, 1'b0);
    #2;
    RST_N = 1'b0;
    push("async_rst", 0, 4'h0, 4'h0, 4'h0, 1'b0);
    #1;
    compare();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int k = 1; k <= 3; k++) step("post_rst", 0, 4'h0, 4'h0, 4'h0, 1'b0);

    // SIZE=4 without a synchroniser: rise after SIZE+1 edges.
    bus1.CE = 1'b1;
    bus1.D  = 1'b1;
    for (int k = 1; k <= 4; k++) step("h_wait", 1, 4'h0, 4'h0, 4'h0, 1'b0);
    step("h_rise", 1, 4'h1, 4'h1, 4'h0, 1'b1);
    step("h_after", 1, 4'h1, 4'h0, 4'h0, 1'b0);

    // Two low ticks then high again: count 4->2->4, Q stays high.
    bus1.D = 1'b0;
    for (int k = 1; k <= 2; k++) step("h_dip", 1, 4'h1, 4'h0, 4'h0, 1'b0);
    bus1.D = 1'b1;
    for (int k = 1; k <= 3; k++) step("h_back", 1, 4'h1, 4'h0, 4'h0, 1'b0);

    // Sustained low: the count walks down to 0, then FALL.
    bus1.D = 1'b0;
    for (int k = 1; k <= 4; k++) step("h_down", 1, 4'h1, 4'h0, 4'h0, 1'b0);
    step("h_fall", 1, 4'h0, 4'h0, 4'h1, 1'b1);
    step("h_end", 1, 4'h0, 4'h0, 4'h0, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
